// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared limits and helpers for the mux_sel_pipe operand selector.
package mux_sel_pkg;
   localparam int MAX_NUM_IN = 16;
   localparam int ERRCNT_W   = 8;

   function automatic logic sel_ok(input int unsigned s, input int unsigned n);
      return s < n;
   endfunction
endpackage

// File: rtl/sel_fifo2.sv
// sel_fifo2: 2-entry valid/ready FIFO; in_ready depends only on the registered count.
module sel_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_q, wr_d, rd_q, rd_d, push, pop;
   logic [1:0]   cnt_q, cnt_d;

   assign in_ready  = cnt_q != 2'd2;
   assign out_valid = cnt_q != 2'd0;
   assign out_data  = mem_q[rd_q];

   always_comb begin
      push     = in_valid & in_ready;
      pop      = out_valid & out_ready;
      mem_d[0] = (push && !wr_q) ? in_data : mem_q[0];
      mem_d[1] = (push && wr_q) ? in_data : mem_q[1];
      wr_d     = wr_q ^ push;
      rd_d     = rd_q ^ pop;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-way selector with out-of-range flag, buffered in a 2-entry FIFO.
// Define MUX_SEL_ERRCNT_EN to add the saturating err_count output.
module mux_sel_pipe
   import mux_sel_pkg::*;
#(
   parameter int  WIDTH  = 16,
   parameter int  NUM_IN = 6,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    CLK,
   input  logic                    Reset_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_err,
   output logic                    out_valid,
`ifdef MUX_SEL_ERRCNT_EN
   input  logic                    out_ready,
   output logic [ERRCNT_W-1:0]     err_count
`else
   input  logic                    out_ready
`endif
);
   typedef struct packed {
      logic             err;
      logic [WIDTH-1:0] data;
   } entry_t;

   logic [WIDTH-1:0] words [NUM_IN];
   entry_t           in_entry, out_entry;
   logic             in_ok;

   if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
      $error("mux_sel_pipe: NUM_IN must be 2..%0d", MAX_NUM_IN);
   end

   for (genvar g = 0; g < NUM_IN; g++) begin : g_word
      assign words[g] = in_data[g*WIDTH +: WIDTH];
   end

   // Out-of-range selects still occupy a slot so the downstream sees the error in order.
   always_comb begin
      in_ok    = sel_ok(32'(sel), NUM_IN);
      in_entry = '{err: !in_ok, data: in_ok ? words[sel] : '0};
   end

   sel_fifo2 #(.W(WIDTH + 1)) u_fifo (
      .clk      (CLK),
      .rst_n    (Reset_n),
      .in_data  (in_entry),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_entry),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   assign out_data = out_entry.data;
   assign out_err  = out_entry.err;

`ifdef MUX_SEL_ERRCNT_EN
   logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb
      err_cnt_d = (in_valid && in_ready && !in_ok && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed vectors against a queue model of the selector FIFO.
module tb_mux_sel_pipe;
   localparam int W = 16, N = 6, SW = 3;

   logic          CLK = 1'b0, Reset_n = 1'b0;
   logic [N*W-1:0] in_data;
   logic [SW-1:0] sel = '0;
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic          in_ready, out_valid, out_err;
   logic [W-1:0]  out_data;
`ifdef MUX_SEL_ERRCNT_EN
   logic [7:0]    err_count;
`endif

   int errors = 0, checks = 0;
   int exp_errcnt = 0;
   logic [W-1:0] words [N] = '{16'd2000, 16'd55, 16'd78, 16'd33, 16'd4, 16'd999};

   typedef struct {
      logic         err;
      logic [W-1:0] data;
   } ent_t;
   ent_t q[$];
   bit   m_acc, m_pop;

   always #5 CLK = ~CLK;

   mux_sel_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
      .CLK      (CLK),
      .Reset_n  (Reset_n),
      .in_data  (in_data),
      .sel      (sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_err  (out_err),
      .out_valid(out_valid),
`ifdef MUX_SEL_ERRCNT_EN
      .out_ready(out_ready),
      .err_count(err_count)
`else
      .out_ready(out_ready)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [SW-1:0] s, input logic r);
      @(negedge CLK);
      #1;
      in_valid  = v;
      sel       = s;
      out_ready = r;
   endtask

   task automatic settle();
      @(posedge CLK);
      #1;
   endtask

   always @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         q.delete();
         exp_errcnt = 0;
      end else begin
         m_acc = in_valid && q.size() < 2;
         m_pop = out_ready && q.size() > 0;
         if (m_pop) void'(q.pop_front());
         if (m_acc) begin
            if (int'(sel) < N) q.push_back('{1'b0, words[sel]});
            else begin
               q.push_back('{1'b1, '0});
               if (exp_errcnt < 255) exp_errcnt++;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (Reset_n) begin
         chk("model_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("model_ready", 32'(in_ready), 32'(q.size() < 2));
         if (q.size() != 0) begin
            chk("model_data", 32'(out_data), 32'(q[0].data));
            chk("model_err", 32'(out_err), 32'(q[0].err));
         end
`ifdef MUX_SEL_ERRCNT_EN
         chk("model_errcnt", 32'(err_count), 32'(exp_errcnt));
`endif
      end
   end

   initial begin
      int exp_vals[6] = '{2000, 55, 78, 33, 4, 999};
      for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_err", 32'(out_err), 0);
`ifdef MUX_SEL_ERRCNT_EN
      chk("rst_errcnt", 32'(err_count), 0);
`endif
      @(negedge CLK);
      Reset_n = 1'b1;

      for (int i = 0; i < N; i++) begin
         cyc(1'b1, SW'(i), 1'b1);
         settle();
         chk("sel_valid", 32'(out_valid), 1);
         chk("sel_data", 32'(out_data), 32'(exp_vals[i]));
         chk("sel_err", 32'(out_err), 0);
      end

      cyc(1'b1, 3'd6, 1'b1);
      settle();
      chk("bad6_data", 32'(out_data), 0);
      chk("bad6_err", 32'(out_err), 1);
      cyc(1'b1, 3'd7, 1'b1);
      settle();
      chk("bad7_data", 32'(out_data), 0);
      chk("bad7_err", 32'(out_err), 1);
`ifdef MUX_SEL_ERRCNT_EN
      chk("bad_errcnt", 32'(err_count), 2);
`endif
      cyc(1'b0, 3'd0, 1'b1);

      cyc(1'b1, 3'd1, 1'b0);
      cyc(1'b1, 3'd2, 1'b0);
      settle();
      chk("full_ready", 32'(in_ready), 0);
      cyc(1'b1, 3'd3, 1'b0);
      settle();
      chk("held_ready", 32'(in_ready), 0);
      chk("held_data", 32'(out_data), 55);
      cyc(1'b1, 3'd3, 1'b1);
      settle();
      chk("rel_data1", 32'(out_data), 78);
      chk("rel_ready", 32'(in_ready), 1);
      cyc(1'b1, 3'd3, 1'b1);
      settle();
      chk("rel_data2", 32'(out_data), 33);
      cyc(1'b0, 3'd0, 1'b1);

      cyc(1'b1, 3'd0, 1'b0);
      cyc(1'b1, 3'd5, 1'b1);
      settle();
      chk("pp_valid", 32'(out_valid), 1);
      chk("pp_ready", 32'(in_ready), 1);
      chk("pp_data", 32'(out_data), 999);
      cyc(1'b0, 3'd0, 1'b1);

      cyc(1'b1, 3'd1, 1'b0);
      cyc(1'b1, 3'd2, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      chk("pre_rst_full", 32'(in_ready), 0);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_ready", 32'(in_ready), 1);
`ifdef MUX_SEL_ERRCNT_EN
      chk("arst_errcnt", 32'(err_count), 0);
`endif
      @(negedge CLK);
      Reset_n = 1'b1;

`ifdef MUX_SEL_ERRCNT_EN
      for (int i = 0; i < 300; i++) cyc(1'b1, 3'd7, 1'b1);
      cyc(1'b0, 3'd0, 1'b1);
      settle();
      chk("sat_errcnt", 32'(err_count), 255);
`endif
      cyc(1'b0, 3'd0, 1'b1);
      settle();
      chk("end_empty", 32'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
